// File: rtl/row_scan_monitor.sv
// Row-scan monitor: decodes active-low one-hot row lines, checks scan order 0..6 (+optional blank) and counts frames.
// Optional 2-flop input synchronizer enabled by defining ROW_MON_INPUT_SYNC_EN.
//
// state | meaning
// HUNT  | waiting for row 0 to align to the scan; no faults raised
// TRACK | aligned; each sample must match the expected row or frame-end slot
module row_scan_monitor #(
  parameter int FRAME_W     = 8,
  parameter int ERR_W       = 4,
  parameter int ALLOW_BLANK = 1
) (
  input  logic               clk_div,
  input  logic               rst,
  input  logic [6:0]         rows_n,
  input  logic               clr_err,
  output logic [2:0]         row_idx,
  output logic               row_valid,
  output logic               blank,
  output logic               locked,
  output logic               frame_pulse,
  output logic [FRAME_W-1:0] frame_count,
  output logic               seq_err,
  output logic [ERR_W-1:0]   err_count
);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t     state_q, state_d;
  logic [2:0] exp_q, exp_d;
  logic       blank_seen_q, blank_seen_d;
  logic [6:0] rows_s;
  logic [2:0] zero_cnt;
  logic [2:0] dec_idx;
  logic       is_one;
  logic       is_blank;
  logic       fault;
  logic       frame_done;

`ifdef ROW_MON_INPUT_SYNC_EN
  logic [6:0] sync1_q, sync2_q;

  // Reset to all-high so the first synchronized samples read as BLANK.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      sync1_q <= 7'h7F;
      sync2_q <= 7'h7F;
    end else begin
      sync1_q <= rows_n;
      sync2_q <= sync1_q;
    end
  end

  assign rows_s = sync2_q;
`else
  assign rows_s = rows_n;
`endif

  always_comb begin
    zero_cnt = 3'd0;
    dec_idx  = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (!rows_s[i]) begin
        zero_cnt = zero_cnt + 3'd1;
        dec_idx  = 3'(i);
      end
    end
  end

  assign is_one   = (zero_cnt == 3'd1);
  assign is_blank = (rows_s == 7'h7F);

  // exp_q == 0 while tracking means row 6 was accepted and the frame-end slot is due.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    blank_seen_d = blank_seen_q;
    fault        = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      HUNT: begin
        if (is_one && dec_idx == 3'd0) begin
          state_d      = TRACK;
          exp_d        = 3'd1;
          blank_seen_d = 1'b0;
        end
      end
      TRACK: begin
        if (exp_q != 3'd0) begin
          if (is_one && dec_idx == exp_q)
            exp_d = (exp_q == 3'd6) ? 3'd0 : exp_q + 3'd1;
          else
            fault = 1'b1;
        end else if (is_one && dec_idx == 3'd0) begin
          frame_done   = 1'b1;
          exp_d        = 3'd1;
          blank_seen_d = 1'b0;
        end else if (is_blank && (ALLOW_BLANK != 0) && !blank_seen_q) begin
          blank_seen_d = 1'b1;
        end else begin
          fault = 1'b1;
        end
        if (fault) begin
          state_d      = HUNT;
          exp_d        = 3'd0;
          blank_seen_d = 1'b0;
        end
      end
      default: begin
        state_d      = HUNT;
        exp_d        = 3'd0;
        blank_seen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      exp_q        <= 3'd0;
      blank_seen_q <= 1'b0;
      row_idx      <= 3'd0;
      row_valid    <= 1'b0;
      blank        <= 1'b0;
      frame_pulse  <= 1'b0;
      frame_count  <= '0;
      seq_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      blank_seen_q <= blank_seen_d;
      row_valid    <= is_one;
      blank        <= is_blank;
      frame_pulse  <= frame_done;
      if (is_one)
        row_idx <= dec_idx;
      if (frame_done)
        frame_count <= frame_count + FRAME_W'(1);
      // A fault on the same edge as clr_err restarts the count at one.
      if (fault) begin
        seq_err <= 1'b1;
        if (clr_err)
          err_count <= ERR_W'(1);
        else if (err_count != {ERR_W{1'b1}})
          err_count <= err_count + ERR_W'(1);
      end else if (clr_err) begin
        seq_err   <= 1'b0;
        err_count <= '0;
      end
    end
  end

  assign locked = (state_q == TRACK);

endmodule

// File: tb/tb_row_scan_monitor.sv
// Randomized self-checking bench for row_scan_monitor against a frame-level reference model.
// Honors ROW_MON_INPUT_SYNC_EN by adjusting the expected input latency.
module tb_row_scan_monitor;
  localparam int FRAME_W     = 8;
  localparam int ERR_W       = 4;
  localparam int ALLOW_BLANK = 1;
`ifdef ROW_MON_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic               clk_div;
  logic               rst;
  logic [6:0]         rows_n;
  logic               clr_err;
  logic [2:0]         row_idx;
  logic               row_valid;
  logic               blank;
  logic               locked;
  logic               frame_pulse;
  logic [FRAME_W-1:0] frame_count;
  logic               seq_err;
  logic [ERR_W-1:0]   err_count;

  int total = 0;
  int bad   = 0;

  // Reference model state: m_next counts the row due next, 7 meaning the frame-end slot.
  logic [2:0]         m_idx;
  logic               m_valid, m_blank, m_locked, m_pulse, m_err;
  logic [FRAME_W-1:0] m_fcount;
  logic [ERR_W-1:0]   m_ecount;
  int                 m_next;
  bit                 m_blank_used;
  logic [6:0]         m_pipe0, m_pipe1;

  logic [19:0] dut_vec, model_vec;
  assign dut_vec   = {row_idx, row_valid, blank, locked, frame_pulse, frame_count, seq_err, err_count};
  assign model_vec = {m_idx, m_valid, m_blank, m_locked, m_pulse, m_fcount, m_err, m_ecount};

  row_scan_monitor #(.FRAME_W(FRAME_W), .ERR_W(ERR_W), .ALLOW_BLANK(ALLOW_BLANK)) dut (
    .clk_div    (clk_div),
    .rst        (rst),
    .rows_n     (rows_n),
    .clr_err    (clr_err),
    .row_idx    (row_idx),
    .row_valid  (row_valid),
    .blank      (blank),
    .locked     (locked),
    .frame_pulse(frame_pulse),
    .frame_count(frame_count),
    .seq_err    (seq_err),
    .err_count  (err_count)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [6:0] code(input int r);
    logic [6:0] one_hot;
    one_hot = 7'd1 << r;
    return 7'h7F ^ one_hot;
  endfunction

  task automatic model_reset();
    m_idx = 3'd0; m_valid = 1'b0; m_blank = 1'b0; m_locked = 1'b0; m_pulse = 1'b0;
    m_fcount = '0; m_err = 1'b0; m_ecount = '0;
    m_next = 0; m_blank_used = 1'b0;
    m_pipe0 = 7'h7F; m_pipe1 = 7'h7F;
  endtask

  task automatic model_edge(input logic [6:0] x, input logic c);
    logic [6:0] seen;
    int zeros, pos;
    bit one, blk, fault;
    if (LAT == 1) seen = x;
    else begin
      seen = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = x;
    end
    zeros = 0; pos = 0;
    for (int i = 0; i < 7; i++)
      if (seen[i] == 1'b0) begin zeros++; pos = i; end
    one = (zeros == 1);
    blk = (seen == 7'h7F);
    fault = 1'b0;
    m_pulse = 1'b0;
    if (!m_locked) begin
      if (one && pos == 0) begin m_locked = 1'b1; m_next = 1; m_blank_used = 1'b0; end
    end else if (m_next <= 6) begin
      if (one && pos == m_next) m_next++;
      else fault = 1'b1;
    end else if (one && pos == 0) begin
      m_pulse = 1'b1; m_fcount = m_fcount + 1'b1; m_next = 1; m_blank_used = 1'b0;
    end else if (blk && ALLOW_BLANK != 0 && !m_blank_used) begin
      m_blank_used = 1'b1;
    end else begin
      fault = 1'b1;
    end
    if (fault) m_locked = 1'b0;
    if (fault) begin
      m_err = 1'b1;
      if (c) m_ecount = 1;
      else if (m_ecount != {ERR_W{1'b1}}) m_ecount = m_ecount + 1'b1;
    end else if (c) begin
      m_err = 1'b0; m_ecount = '0;
    end
    m_valid = one;
    m_blank = blk;
    if (one) m_idx = 3'(pos);
  endtask

  task automatic step(input logic [6:0] x, input logic c);
    @(negedge clk_div);
    rows_n  = x;
    clr_err = c;
    @(posedge clk_div);
    model_edge(x, c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_div);
    rst = 1'b1; rows_n = 7'h7F; clr_err = 1'b0;
    @(posedge clk_div);
    @(negedge clk_div);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; rows_n = 7'h7F; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_div);
    #1;
    total++;
    if (dut_vec !== 20'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec, 20'd0);
    end
    @(negedge clk_div);
    rst = 1'b0;
  endtask

  task automatic test_clean_frames();
    int pulses = 0;
    do_reset();
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 7; r++) begin
        step(code(r), 1'b0);
        if (frame_pulse) pulses++;
        total++;
        if (dut_vec !== model_vec) begin
          bad++; $display("FAIL clean f%0d r%0d: got %h want %h", f, r, dut_vec, model_vec);
        end
        if (f == 0 && r == 0) begin
          total++;
          if (locked !== (LAT == 1 ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL clean_first_lock: got %b want %b", locked, LAT == 1);
          end
        end
      end
    step(code(0), 1'b0);
    if (frame_pulse) pulses++;
    for (int k = 1; k < LAT; k++) begin
      step(code(k), 1'b0);
      if (frame_pulse) pulses++;
    end
    total++;
    if (dut_vec !== model_vec) begin
      bad++; $display("FAIL clean_end: got %h want %h", dut_vec, model_vec);
    end
    total++;
    if (pulses != 3 || frame_count !== 8'd3 || seq_err !== 1'b0) begin
      bad++; $display("FAIL clean_totals: got pulses=%0d count=%0d err=%b want 3 3 0", pulses, frame_count, seq_err);
    end
  endtask

  task automatic test_blank();
    int pulses = 0;
    logic [6:0] seq1 [9];
    do_reset();
    for (int r = 0; r < 7; r++) seq1[r] = code(r);
    seq1[7] = 7'h7F; seq1[8] = code(0);
    for (int i = 0; i < 9; i++) begin
      step(seq1[i], 1'b0);
      if (frame_pulse) pulses++;
      total++;
      if (dut_vec !== model_vec) begin
        bad++; $display("FAIL blank_one i%0d: got %h want %h", i, dut_vec, model_vec);
      end
    end
    for (int k = 1; k < LAT; k++) begin
      step(code(k), 1'b0);
      if (frame_pulse) pulses++;
    end
    total++;
    if (pulses != 1 || seq_err !== 1'b0) begin
      bad++; $display("FAIL blank_one_totals: got pulses=%0d err=%b want 1 0", pulses, seq_err);
    end
    for (int r = LAT; r < 7; r++) step(code(r), 1'b0);
    step(7'h7F, 1'b0);
    step(7'h7F, 1'b0);
    for (int k = 1; k < LAT; k++) step(7'h7F, 1'b0);
    total++;
    if (seq_err !== 1'b1 || err_count !== 4'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL blank_two: got err=%b cnt=%0d lock=%b want 1 1 0", seq_err, err_count, locked);
    end
    total++;
    if (dut_vec !== model_vec) begin
      bad++; $display("FAIL blank_two_model: got %h want %h", dut_vec, model_vec);
    end
  endtask

  task automatic test_skip();
    int pulses = 0;
    int rs [4] = '{0, 1, 2, 4};
    do_reset();
    foreach (rs[i]) step(code(rs[i]), 1'b0);
    for (int k = 1; k < LAT; k++) step(7'h7F, 1'b0);
    total++;
    if (seq_err !== 1'b1 || err_count !== 4'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL skip_fault: got err=%b cnt=%0d lock=%b want 1 1 0", seq_err, err_count, locked);
    end
    step(code(0), 1'b0);
    if (frame_pulse) pulses++;
    for (int k = 1; k < LAT; k++) begin
      step(code(k), 1'b0);
      if (frame_pulse) pulses++;
    end
    total++;
    if (locked !== 1'b1 || pulses != 0 || frame_count !== 8'd0) begin
      bad++; $display("FAIL skip_relock: got lock=%b pulses=%0d count=%0d want 1 0 0", locked, pulses, frame_count);
    end
  endtask

  task automatic test_bad_sample();
    do_reset();
    for (int r = 0; r < 3; r++) step(code(r), 1'b0);
    step(7'b1111100, 1'b0);
    for (int k = 1; k < LAT; k++) step(7'h7F, 1'b0);
    total++;
    if (row_valid !== 1'b0 || blank !== 1'b0 || row_idx !== 3'd2 || seq_err !== 1'b1 || locked !== 1'b0) begin
      bad++; $display("FAIL bad_sample: got v=%b b=%b idx=%0d err=%b lock=%b want 0 0 2 1 0",
                      row_valid, blank, row_idx, seq_err, locked);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      step(code(0), 1'b0);
      step(code(2), 1'b0);
      total++;
      if (dut_vec !== model_vec) begin
        bad++; $display("FAIL sat n%0d: got %h want %h", n, dut_vec, model_vec);
      end
    end
    for (int k = 1; k < LAT; k++) step(7'h7F, 1'b0);
    total++;
    if (err_count !== 4'd15 || seq_err !== 1'b1) begin
      bad++; $display("FAIL sat_level: got cnt=%0d err=%b want 15 1", err_count, seq_err);
    end
    step(code(0), 1'b0);
    step(code(2), LAT == 1 ? 1'b1 : 1'b0);
    for (int k = 1; k < LAT; k++) step(7'h7F, k == LAT - 1 ? 1'b1 : 1'b0);
    total++;
    if (seq_err !== 1'b1 || err_count !== 4'd1) begin
      bad++; $display("FAIL clr_vs_fault: got err=%b cnt=%0d want 1 1", seq_err, err_count);
    end
    step(7'h7F, 1'b1);
    total++;
    if (seq_err !== 1'b0 || err_count !== 4'd0) begin
      bad++; $display("FAIL clr_only: got err=%b cnt=%0d want 0 0", seq_err, err_count);
    end
  endtask

  task automatic test_random();
    int gen_r = 0;
    int p;
    logic [6:0] x;
    logic c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      p = $urandom_range(0, 99);
      if (p < 6) x = 7'($urandom_range(0, 127));
      else if (p < 10) x = code($urandom_range(0, 6));
      else if (p < 16) x = 7'h7F;
      else begin
        x = code(gen_r);
        gen_r = (gen_r + 1) % 7;
      end
      c = ($urandom_range(0, 24) == 0);
      step(x, c);
      total++;
      if (dut_vec !== model_vec) begin
        bad++; $display("FAIL random i%0d in=%b clr=%b: got %h want %h", i, x, c, dut_vec, model_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int edges = 0;
    do_reset();
    for (int r = 0; r < 7; r++) step(code(r), 1'b0);
    for (int r = 0; r < 4; r++) step(code(r), 1'b0);
    @(negedge clk_div);
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (dut_vec !== 20'd0) begin
      bad++; $display("FAIL reset_mid: got %h want %h", dut_vec, 20'd0);
    end
    @(negedge clk_div);
    rst = 1'b0;
    rows_n = code(0);
    while (locked !== 1'b1 && edges < 8) begin
      @(posedge clk_div);
      #1;
      edges++;
    end
    total++;
    if (edges != LAT || frame_count !== 8'd0) begin
      bad++; $display("FAIL lock_latency: got edges=%0d count=%0d want %0d 0", edges, frame_count, LAT);
    end
  endtask

  initial begin
    rows_n = 7'h7F;
    clr_err = 1'b0;
    rst = 1'b1;
    test_reset();
    test_clean_frames();
    test_blank();
    test_skip();
    test_bad_sample();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_scan_monitor.md
Name: row_scan_monitor

Overview:
- Receiving end of the LED-matrix row-scan interface: 7 active-low one-hot row-enable lines, row i lit when its line is 0.
- Samples the lines and encodes them back to a 3-bit row index.
- Checks the scan order 0→1→…→6 (optional blank slot) → 0, counts completed frames and flags sequencing faults.
- Sits beside the row driver as a self-check and frame-sync source for the column-data logic.

Parameters:
- FRAME_W, 8, width of the frame counter (wraps).
- ERR_W, 4, width of the error counter (saturates).
- ALLOW_BLANK, 1, when 1 a single all-high slot (no row lit) is legal between row 6 and row 0.

Ports:
- clk_div  in  1  scan clock, rising edge; same clock as the row driver.
- rst  in  1  asynchronous, active-high reset.
- rows_n  in  7  row lines; bit i is row i, active-low.
- clr_err  in  1  synchronous clear of seq_err and err_count.
- row_idx  out  3  index of the lit row in the last sample.
- row_valid  out  1  last sample had exactly one line low.
- blank  out  1  last sample was all high (7'h7F).
- locked  out  1  FSM is in TRACK.
- frame_pulse  out  1  one-cycle pulse on each completed frame.
- frame_count  out  FRAME_W  number of completed frames, wraps.
- seq_err  out  1  sticky fault flag.
- err_count  out  ERR_W  number of faults, saturating.

Behaviour:
- Reset (async, rst=1):
  - all outputs 0, row_idx=0, FSM=HUNT, expected-row register=0.
  - Release takes effect at the next clk_div edge.
- Decode is combinational on rows_n (or on the synchronized copy); all outputs are registered, so latency is 1 clk_div edge.
- Decode classes:
  - ONE: exactly one bit 0. row_valid=1, row_idx=position of that bit.
  - BLANK: 7'h7F. blank=1, row_valid=0, row_idx holds its previous value.
  - BAD: two or more bits 0. row_valid=0, blank=0, row_idx holds.
- FSM states: HUNT, TRACK.
- HUNT:
  - Ignore everything except ONE with idx 0.
  - On ONE idx 0: go to TRACK, expected=1, no frame_pulse.
  - No errors are raised while in HUNT.
- TRACK, per edge:
  - ONE with idx=expected, expected in 1..6: accept; expected increments (6 is followed by the frame-end slot).
  - After row 6 is accepted:
    - BLANK is legal only if ALLOW_BLANK=1, and only once; expected stays 0.
    - ONE idx 0 completes the frame: frame_pulse=1 for one cycle, frame_count+1 (wraps at 2^FRAME_W), expected=1.
  - Any other sample (wrong idx, BAD, a second BLANK, or BLANK when ALLOW_BLANK=0) is a fault:
    - seq_err←1 (sticky), err_count+1 (saturates at all-ones), FSM→HUNT, locked=0 on the same edge.
    - No frame_pulse.
- A fault sample that is itself ONE idx 0 goes to HUNT, not directly back to TRACK; relock needs the next row 0.
- clr_err=1: seq_err←0, err_count←0 at the edge. If a fault occurs on the same edge, the fault wins: seq_err=1, err_count=1.
- clr_err does not affect the FSM, frame_count or locked.
- rst asserted mid-frame: immediate return to reset values. Frames in progress are discarded without error.
- frame_count is not cleared by clr_err; only rst clears it.

Optional Feature:
- Macro ROW_MON_INPUT_SYNC_EN.
- Defined:
  - rows_n passes through a 2-flop synchronizer clocked by clk_div, reset to 7'h7F by rst.
  - Total latency is 3 edges.
  - The first synchronized samples after reset are BLANK; these are ignored because the FSM starts in HUNT.
- Undefined:
  - rows_n feeds the decode directly; latency is 1 edge.
  - rows_n must be driven synchronously to clk_div.

Test Plan:
- Reset then 3 clean frames (rows 0..6, 0..6, 0..6, then 0): locked=1 after the first edge; frame_pulse exactly 3 times; frame_count=3; seq_err=0.
- ALLOW_BLANK=1, frame as rows 0..6, 7'h7F, 0: one frame_pulse, no error. Same frame with two BLANK slots: seq_err=1, err_count=1, locked=0.
- Skipped row (0,1,2,4): at the edge sampling row 4, seq_err=1, err_count=1, FSM HUNT. Next row 0 relocks with no frame_pulse.
- BAD sample 7'b1111100 while TRACK: row_valid=0, row_idx holds its last value, fault raised.
- 20 faults with ERR_W=4: err_count saturates at 15. clr_err on the same edge as a fault: seq_err=1, err_count=1.
- rst asserted between clk_div edges mid-frame: all outputs 0 immediately, frame_count=0. With ROW_MON_INPUT_SYNC_EN defined, lock appears 2 edges later than without it.
